// File: rtl/tdc_hit_timestamper.sv
// tdc_hit_timestamper: detects hits on the fine count, tags them with a coarse count, buffers in a show-ahead FIFO.
// Optional rollover marker words are enabled by defining TDC_ROLLOVER_MARKER_EN.
`default_nettype none
module tdc_hit_timestamper #(
  parameter int FINE_W     = 5,
  parameter int FINE_MAX   = 18,
  parameter int COARSE_W   = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                         i_Clk,
  input  logic                         i_Reset,
  input  logic                         i_Enable,
  input  logic [FINE_W-1:0]            i_Fine_Count,
  output logic [COARSE_W+FINE_W:0]     o_Ts_Data,
  output logic                         o_Ts_Valid,
  input  logic                         i_Ts_Ready,
  output logic [$clog2(FIFO_DEPTH):0]  o_Fifo_Level,
  output logic                         o_Overflow
);

  localparam int DATA_W = 1 + COARSE_W + FINE_W;
  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = ADDR_W + 1;
`ifdef TDC_ROLLOVER_MARKER_EN
  localparam int MEM_W  = DATA_W;
`else
  localparam int MEM_W  = DATA_W - 1;
`endif

  localparam logic [FINE_W-1:0] FINE_MAX_V = FINE_W'(FINE_MAX);
  localparam logic [LVL_W-1:0]  DEPTH_V    = LVL_W'(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_ZERO = 2'd1;
  localparam logic [1:0] ST_ARMED     = 2'd2;
  localparam logic [1:0] ST_CAPTURED  = 2'd3;

  logic [1:0]          state;
  logic [COARSE_W-1:0] coarse;
  logic [FINE_W-1:0]   fine_clamped;
  logic                fine_zero;
  logic                hit_push;
  logic                push_valid;
  logic [MEM_W-1:0]    push_data;
  logic [MEM_W-1:0]    hit_word;

  logic [MEM_W-1:0]    mem [FIFO_DEPTH];
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]   rd_ptr;
  logic [LVL_W-1:0]    level;
  logic                full;
  logic                pop;
  logic                do_write;
  logic [MEM_W-1:0]    head;

  assign fine_zero    = (i_Fine_Count == '0);
  assign fine_clamped = (i_Fine_Count > FINE_MAX_V) ? FINE_MAX_V : i_Fine_Count;
  assign hit_push     = i_Enable && (state == ST_ARMED) && !fine_zero;

  always_ff @(posedge i_Clk) begin
    if (i_Reset || !i_Enable) begin
      coarse <= '0;
    end else begin
      coarse <= coarse + COARSE_W'(1);
    end
  end

  // Waiting for a zero first avoids a false hit when enable rises on a populated line.
  always_ff @(posedge i_Clk) begin
    if (i_Reset || !i_Enable) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:      state <= ST_WAIT_ZERO;
        ST_WAIT_ZERO: if (fine_zero)  state <= ST_ARMED;
        ST_ARMED:     if (!fine_zero) state <= ST_CAPTURED;
        ST_CAPTURED:  if (fine_zero)  state <= ST_ARMED;
        default:      state <= ST_IDLE;
      endcase
    end
  end

`ifdef TDC_ROLLOVER_MARKER_EN
  localparam logic [MEM_W-1:0] MARKER_WORD = {1'b1, {(MEM_W-1){1'b0}}};

  logic wrap;
  logic marker_pending;

  assign wrap     = i_Enable && (coarse == '1);
  assign hit_word = {1'b0, coarse, fine_clamped};

  // A hit wins the write slot; a due marker waits one cycle in the pending register.
  always_comb begin
    push_valid = hit_push || (i_Enable && (wrap || marker_pending));
    push_data  = hit_push ? hit_word : MARKER_WORD;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      marker_pending <= 1'b0;
    end else begin
      marker_pending <= hit_push && (wrap || marker_pending);
    end
  end
`else
  assign hit_word = {coarse, fine_clamped};

  always_comb begin
    push_valid = hit_push;
    push_data  = hit_word;
  end
`endif

  assign o_Ts_Valid = (level != '0);
  assign full       = (level == DEPTH_V);
  assign pop        = o_Ts_Valid && i_Ts_Ready;
  assign do_write   = push_valid && (!full || pop);

  always_ff @(posedge i_Clk) begin
    if (do_write) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      o_Overflow <= 1'b0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)      rd_ptr <= rd_ptr + ADDR_W'(1);
      if (push_valid && full && !pop) o_Overflow <= 1'b1;
      case ({do_write, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  assign head         = o_Ts_Valid ? mem[rd_ptr] : '0;
  assign o_Fifo_Level = level;

`ifdef TDC_ROLLOVER_MARKER_EN
  assign o_Ts_Data = head;
`else
  assign o_Ts_Data = {1'b0, head};
`endif

endmodule
`default_nettype wire

// File: tb/tb_tdc_hit_timestamper.sv
// Bench for tdc_hit_timestamper: directed scenarios then random traffic against a queue-based model.
`default_nettype none
module tb_tdc_hit_timestamper;

  localparam int CW    = 4;
  localparam int FW    = 5;
  localparam int DEPTH = 8;
  localparam int DW    = 1 + CW + FW;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [FW-1:0] fine;
  logic [DW-1:0] ts_data;
  logic          ts_valid;
  logic          ts_ready;
  logic [LW-1:0] fifo_level;
  logic          overflow;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] q[$];
  bit            m_ovf;
  bit            m_pend;
  int            run;
  bit            prev_zero;

  always #5 clk = ~clk;

  tdc_hit_timestamper #(
    .FINE_W(FW), .FINE_MAX(18), .COARSE_W(CW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .i_Clk(clk), .i_Reset(rst), .i_Enable(en), .i_Fine_Count(fine),
    .o_Ts_Data(ts_data), .o_Ts_Valid(ts_valid), .i_Ts_Ready(ts_ready),
    .o_Fifo_Level(fifo_level), .o_Overflow(overflow)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: check outputs against the model, drive inputs, advance the model over the edge.
  task automatic step(input bit r, input bit e, input logic [FW-1:0] f, input bit rd);
    bit            pop, hit, push, wrap;
    logic [DW-1:0] w;
    logic [FW-1:0] fc;
    int            age;
    chk("valid", 32'(ts_valid), 32'(q.size() != 0));
    chk("level", 32'(fifo_level), 32'(q.size()));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (q.size() != 0) chk("head", 32'(ts_data), 32'(q[0]));
    rst = r; en = e; fine = f; ts_ready = rd;
    if (r) begin
      q.delete(); m_ovf = 0; m_pend = 0; run = 0; prev_zero = 0;
    end else begin
      pop = (q.size() != 0) && rd;
      hit = 0; push = 0; wrap = 0; w = '0;
      if (e) begin
        age  = run;
        fc   = (f > 5'd18) ? 5'd18 : f;
        hit  = (f != 0) && (age >= 2) && prev_zero;
        wrap = (age % (1 << CW)) == ((1 << CW) - 1);
        prev_zero = (f == 0);
        run++;
        if (hit) begin
          push = 1;
          w = {1'b0, CW'(age % (1 << CW)), fc};
        end
      end else begin
        run = 0; prev_zero = 0;
      end
`ifdef TDC_ROLLOVER_MARKER_EN
      if (!e) begin
        m_pend = 0;
      end else if (wrap || m_pend) begin
        if (hit) begin
          m_pend = 1;
        end else begin
          m_pend = 0;
          push = 1;
          w = {1'b1, {(DW-1){1'b0}}};
        end
      end
`else
      if (wrap) m_pend = 0;
`endif
      if (push && !(q.size() < DEPTH || pop)) begin
        m_ovf = 1;
        push = 0;
      end
      if (pop) void'(q.pop_front());
      if (push) q.push_back(w);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1; en = 0; fine = '0; ts_ready = 0;
    q.delete(); m_ovf = 0; m_pend = 0; run = 0; prev_zero = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(ts_valid), 0);
    chk("rst_data", 32'(ts_data), 0);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_overflow", 32'(overflow), 0);

    // Hit at coarse 12 after a run of zeros
    for (int i = 0; i < 12; i++) step(0, 1, 0, 0);
    chk("t1_pre_valid", 32'(ts_valid), 0);
    step(0, 1, 7, 0);
    chk("t1_valid", 32'(ts_valid), 1);
    chk("t1_data", 32'(ts_data), 32'({1'b0, 4'd12, 5'd7}));
    chk("t1_level", 32'(fifo_level), 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);

    // Enable rising onto a populated line must not produce a hit
    for (int i = 0; i < 4; i++) step(0, 0, 18, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 18, 0);
    chk("t2_nohit", 32'(fifo_level), 0);
    step(0, 1, 0, 0);
    step(0, 1, 5, 0);
    chk("t2_level", 32'(fifo_level), 1);
    chk("t2_data", 32'(ts_data), 32'({1'b0, 4'd9, 5'd5}));
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);

    // Hit on the wrapping coarse value
    for (int i = 0; i < 15; i++) step(0, 1, 0, 0);
    step(0, 1, 3, 0);
    chk("t6_hit", 32'(ts_data), 32'({1'b0, 4'd15, 5'd3}));
    step(0, 1, 0, 0);
`ifdef TDC_ROLLOVER_MARKER_EN
    chk("t6_level", 32'(fifo_level), 2);
`else
    chk("t6_level", 32'(fifo_level), 1);
`endif
    step(0, 0, 0, 1);
`ifdef TDC_ROLLOVER_MARKER_EN
    chk("t6_marker", 32'(ts_data), 32'({1'b1, 4'd0, 5'd0}));
`else
    chk("t6_empty", 32'(ts_valid), 0);
`endif
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);

    // Clamp and single capture per pulse
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 25, 0);
    for (int i = 0; i < 9; i++) step(0, 1, 25, 0);
    chk("t5_level", 32'(fifo_level), 1);
    chk("t5_data", 32'(ts_data), 32'({1'b0, 4'd2, 5'd18}));
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);

    // Fill to full in two short segments, then push-with-pop and push-when-full
    step(1, 0, 0, 0);
    for (int s = 0; s < 2; s++) begin
      step(0, 1, 0, 0);
      step(0, 1, 0, 0);
      for (int h = 0; h < 4; h++) begin
        step(0, 1, 3, 0);
        step(0, 1, 0, 0);
      end
      if (s == 0) step(0, 0, 0, 0);
    end
    chk("t3_full", 32'(fifo_level), 8);
    chk("t3_noovf", 32'(overflow), 0);
    step(0, 1, 3, 1);
    chk("t4_level", 32'(fifo_level), 8);
    chk("t4_ovf", 32'(overflow), 0);
    step(0, 1, 0, 0);
    step(0, 1, 3, 0);
    chk("t3_level", 32'(fifo_level), 8);
    chk("t3_ovf", 32'(overflow), 1);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1);
    chk("t3_drained", 32'(ts_valid), 0);
    chk("t3_sticky", 32'(overflow), 1);

    // Random traffic
    step(1, 0, 0, 0);
    for (int i = 0; i < 1500; i++) begin
      bit            r, e, rd;
      logic [FW-1:0] f;
      r  = ($urandom_range(0, 299) == 0);
      e  = ($urandom_range(0, 19) != 0);
      rd = ($urandom_range(0, 3) == 0) ? 1'b1 : ((i / 200) % 2 == 0);
      f  = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      step(r, e, f, rd);
    end
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
